// File: rtl/bnn_fc_pkg.sv
// -----------------------------------------------------------------------------
// bnn_fc_pkg
// Shared definitions for the BNN-VAD fully-connected MAC engine:
//   - default geometry / width constants
//   - FSM state encoding
//   - sat_to_out(): clamp an accumulator to the signed output score range
//   - widx(): flat weight-memory index of (neuron, beat, lane)
// The helper functions are sized by the DEF_* constants, so the engine's
// parameters are expected to stay at these defaults (or the package moves
// with them).
// -----------------------------------------------------------------------------
package bnn_fc_pkg;

    localparam int DEF_IN_LANES = 3;
    localparam int DEF_VEC_LEN  = 36;
    localparam int DEF_N_OUT    = 2;
    localparam int DEF_ACT_W    = 2;
    localparam int DEF_WGT_W    = 2;
    localparam int DEF_ACC_W    = 12;
    localparam int DEF_OUT_W    = 4;
    localparam int DEF_DEPTH    = DEF_N_OUT * DEF_VEC_LEN * DEF_IN_LANES;
    localparam int DEF_ADDR_W   = $clog2(DEF_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Output score limits expressed at accumulator width for signed compares.
    localparam logic signed [DEF_ACC_W-1:0] SAT_MAX = DEF_ACC_W'((2 ** (DEF_OUT_W - 1)) - 1);
    localparam logic signed [DEF_ACC_W-1:0] SAT_MIN = DEF_ACC_W'(-(2 ** (DEF_OUT_W - 1)));

    // Returns {ovf, value}: value clamped to the signed OUT_W range.
    function automatic logic [DEF_OUT_W:0] sat_to_out(input logic signed [DEF_ACC_W-1:0] acc);
        logic [DEF_OUT_W:0] res;
        if (acc > SAT_MAX) begin
            res = {1'b1, SAT_MAX[DEF_OUT_W-1:0]};
        end else if (acc < SAT_MIN) begin
            res = {1'b1, SAT_MIN[DEF_OUT_W-1:0]};
        end else begin
            res = {1'b0, acc[DEF_OUT_W-1:0]};
        end
        return res;
    endfunction

    // Flat weight index: (n*VEC_LEN + beat)*IN_LANES + lane.
    function automatic int widx(input int n, input int beat, input int lane);
        return (n * DEF_VEC_LEN + beat) * DEF_IN_LANES + lane;
    endfunction

endpackage

// File: rtl/bnn_fc_acc_chk.sv
// -----------------------------------------------------------------------------
// bnn_fc_acc_chk
// Simulation checker: flags an accumulator update that would wrap, which only
// happens when ACC_W is too narrow for the configured vector.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   en          an accumulate (not a load) happens this cycle
//   base        current accumulator value
//   addend      beat sum being added
// -----------------------------------------------------------------------------
module bnn_fc_acc_chk #(
    parameter int ACC_W = 12
) (
    input logic                    clk,
    input logic                    rst_n,
    input logic                    en,
    input logic signed [ACC_W-1:0] base,
    input logic signed [ACC_W-1:0] addend
);

    logic signed [ACC_W:0] wide_s;

    assign wide_s = {base[ACC_W-1], base} + {addend[ACC_W-1], addend};

    acc_no_wrap: assert property (@(posedge clk) disable iff (!rst_n)
        en |-> (wide_s[ACC_W] == wide_s[ACC_W-1]));

endmodule

// File: rtl/bnn_fc_lane_dot.sv
// -----------------------------------------------------------------------------
// bnn_fc_lane_dot
// Combinational per-neuron beat sum: IN_LANES unsigned activations times
// IN_LANES signed weights, summed and sign-extended to ACC_W.
// Ports:
//   act  in   IN_LANES*ACT_W  activations, lane 0 in LSBs
//   wgt  in   IN_LANES*WGT_W  signed weights, lane 0 in LSBs
//   sum  out  ACC_W           signed dot product of this beat
// -----------------------------------------------------------------------------
module bnn_fc_lane_dot #(
    parameter int IN_LANES = 3,
    parameter int ACT_W    = 2,
    parameter int WGT_W    = 2,
    parameter int ACC_W    = 12
) (
    input  logic [IN_LANES*ACT_W-1:0] act,
    input  logic [IN_LANES*WGT_W-1:0] wgt,
    output logic signed [ACC_W-1:0]   sum
);

    localparam int PROD_W = ACT_W + WGT_W + 1;

    logic signed [PROD_W-1:0] prod_s;
    logic signed [ACC_W-1:0]  sum_s;

    // Lane products and adder chain; activation gets a zero sign bit so it
    // multiplies as a non-negative signed value.
    always_comb begin
        prod_s = '0;
        sum_s  = '0;
        for (int l = 0; l < IN_LANES; l++) begin
            prod_s = $signed({1'b0, act[l*ACT_W +: ACT_W]}) * $signed(wgt[l*WGT_W +: WGT_W]);
            sum_s  = sum_s + ACC_W'(prod_s);
        end
    end

    assign sum = sum_s;

endmodule

// File: rtl/bnn_fc_mac_array.sv
// -----------------------------------------------------------------------------
// bnn_fc_mac_array
// Fully-connected MAC engine for the BNN-VAD classifier head. Streams VEC_LEN
// beats of IN_LANES activations, accumulates N_OUT dot products in parallel
// against a runtime-loadable weight memory, and emits saturated scores.
// Ports:
//   clk, rst_n      clock / async active-low reset (released synchronously)
//   wgt_we/addr/data  weight write port, honoured only in IDLE
//   in_valid/ready/data  activation beat stream, lane 0 in LSBs
//   out_valid/ready      result handshake
//   out_data        N_OUT saturated signed scores, neuron 0 in LSBs
//   out_ovf         per-neuron saturation flag
//   busy            high while accumulating or holding a result
// -----------------------------------------------------------------------------
module bnn_fc_mac_array
    import bnn_fc_pkg::*;
#(
    parameter int IN_LANES = DEF_IN_LANES,
    parameter int VEC_LEN  = DEF_VEC_LEN,
    parameter int N_OUT    = DEF_N_OUT,
    parameter int ACT_W    = DEF_ACT_W,
    parameter int WGT_W    = DEF_WGT_W,
    parameter int ACC_W    = DEF_ACC_W,
    parameter int OUT_W    = DEF_OUT_W,
    parameter int ADDR_W   = $clog2(N_OUT * VEC_LEN * IN_LANES)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wgt_we,
    input  logic [ADDR_W-1:0]         wgt_addr,
    input  logic [WGT_W-1:0]          wgt_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IN_LANES*ACT_W-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_OUT*OUT_W-1:0]    out_data,
    output logic [N_OUT-1:0]          out_ovf,
    output logic                      busy
);

    localparam int DEPTH = N_OUT * VEC_LEN * IN_LANES;
    localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);

    state_t                  state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic signed [ACC_W-1:0] acc_r [N_OUT];
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic [N_OUT*OUT_W-1:0]  out_data_r;
    logic [N_OUT-1:0]        out_ovf_r;
    logic                    busy_r;

    logic [WGT_W-1:0]        mem_r [DEPTH];

    logic [IN_LANES*WGT_W-1:0] wvec_s [N_OUT];
    logic signed [ACC_W-1:0]   dot_s [N_OUT];
    logic signed [ACC_W-1:0]   acc_next_s [N_OUT];
    logic [OUT_W-1:0]          sat_val_s [N_OUT];
    logic [N_OUT-1:0]          sat_ovf_s;
    logic                      beat_s;
    logic                      wr_s;
    logic                      last_s;
    logic [CNT_W-1:0]          cnt_next_s;

    // Handshake, write qualification and end-of-vector detection.
    always_comb begin
        beat_s = in_valid & in_ready_r;
        wr_s   = wgt_we && (state_r == IDLE) && (32'(wgt_addr) < 32'(DEPTH));
        case (state_r)
            IDLE:    last_s = (VEC_LEN == 1);
            ACC:     last_s = (cnt_r == CNT_LAST);
            default: last_s = 1'b0;
        endcase
        if (last_s) begin
            cnt_next_s = '0;
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
    end

    // Fetch the weights of the current beat for every neuron/lane.
    always_comb begin
        for (int n = 0; n < N_OUT; n++) begin
            wvec_s[n] = '0;
            for (int l = 0; l < IN_LANES; l++) begin
                wvec_s[n][l*WGT_W +: WGT_W] = mem_r[ADDR_W'(widx(n, int'(cnt_r), l))];
            end
        end
    end

    for (genvar n = 0; n < N_OUT; n++) begin : g_neuron
        bnn_fc_lane_dot #(
            .IN_LANES (IN_LANES),
            .ACT_W    (ACT_W),
            .WGT_W    (WGT_W),
            .ACC_W    (ACC_W)
        ) u_dot (
            .act (in_data),
            .wgt (wvec_s[n]),
            .sum (dot_s[n])
        );

        bnn_fc_acc_chk #(
            .ACC_W (ACC_W)
        ) u_chk (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (beat_s && (state_r == ACC)),
            .base   (acc_r[n]),
            .addend (dot_s[n])
        );
    end

    // Next accumulator value: beat 0 loads (drops stale sums), later beats add.
    always_comb begin
        sat_ovf_s = '0;
        for (int n = 0; n < N_OUT; n++) begin
            acc_next_s[n] = (state_r == ACC) ? (acc_r[n] + dot_s[n]) : dot_s[n];
            {sat_ovf_s[n], sat_val_s[n]} = sat_to_out(acc_next_s[n]);
        end
    end

    // Weight memory: no reset, so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wgt_addr] <= wgt_data;
        end
    end

    // Control FSM with accumulators and registered result/handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_ovf_r   <= '0;
            busy_r      <= 1'b0;
            for (int n = 0; n < N_OUT; n++) begin
                acc_r[n] <= '0;
            end
        end else begin
            case (state_r)
                IDLE, ACC: begin
                    if (beat_s) begin
                        for (int n = 0; n < N_OUT; n++) begin
                            acc_r[n] <= acc_next_s[n];
                        end
                        cnt_r  <= cnt_next_s;
                        busy_r <= 1'b1;
                        if (last_s) begin
                            state_r     <= OUT;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                            out_ovf_r   <= sat_ovf_s;
                            for (int n = 0; n < N_OUT; n++) begin
                                out_data_r[n*OUT_W +: OUT_W] <= sat_val_s[n];
                            end
                        end else begin
                            state_r <= ACC;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= '0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_ovf   = out_ovf_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_bnn_fc_mac_array.sv
module tb_bnn_fc_mac_array;
    import bnn_fc_pkg::*;

    localparam int IL  = 3;
    localparam int VL  = 36;
    localparam int NO  = 2;
    localparam int AW  = 2;
    localparam int WW  = 2;
    localparam int OW  = 4;
    localparam int ADW = 8;

    localparam logic [5:0] D_ONE  = 6'b000001;
    localparam logic [5:0] D_ZERO = 6'b000000;
    localparam logic [5:0] D_ALL3 = 6'b111111;
    localparam logic [1:0] W_P1   = 2'b01;
    localparam logic [1:0] W_M1   = 2'b11;
    localparam logic [1:0] W_M2   = 2'b10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wgt_we = 1'b0;
    logic [ADW-1:0]    wgt_addr = '0;
    logic [WW-1:0]     wgt_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [IL*AW-1:0]  in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [NO*OW-1:0]  out_data;
    logic [NO-1:0]     out_ovf;
    logic              busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bnn_fc_mac_array dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wgt_we    (wgt_we),
        .wgt_addr  (wgt_addr),
        .wgt_data  (wgt_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke_weight(input int addr, input logic [1:0] w);
        wgt_we   = 1'b1;
        wgt_addr = ADW'(addr);
        wgt_data = w;
        tick();
        wgt_we   = 1'b0;
    endtask

    task automatic load_neuron(input int n, input logic [1:0] w);
        for (int b = 0; b < VL; b++) begin
            for (int l = 0; l < IL; l++) begin
                poke_weight(widx(n, b, l), w);
            end
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Feeds beats until stop_after are accepted (bounded); reports how many
    // were accepted, out_valid right after the final one, and any early valid.
    task automatic run_vec(input logic [5:0] d_early, input int n_early,
                           input logic [5:0] d_rest, input bit bubbles,
                           input int stop_after, output int nacc,
                           output bit vlast, output bit early);
        int cyc;
        bit take;
        nacc  = 0;
        vlast = 1'b0;
        early = 1'b0;
        cyc   = 0;
        while (nacc < stop_after && cyc < 2000) begin
            in_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = (nacc < n_early) ? d_early : d_rest;
            take     = in_valid && in_ready;
            tick();
            cyc++;
            if (take) nacc++;
            if (nacc == stop_after) vlast = out_valid;
            else if (out_valid) early = 1'b1;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ovf !== 2'b00 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b data=%h ovf=%b busy=%b, want 0/00/00/0",
                     out_valid, out_data, out_ovf, busy);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        int nacc;
        bit vlast, early;
        load_neuron(0, W_P1);
        load_neuron(1, W_M1);
        run_vec(D_ONE, 5, D_ZERO, 1'b0, VL, nacc, vlast, early);
        total++;
        if (nacc !== VL || vlast !== 1'b1 || early !== 1'b0) begin
            bad++;
            $display("FAIL basic_latency: accepted=%0d valid_after_last=%b early=%b, want %0d/1/0",
                     nacc, vlast, early, VL);
        end
        total++;
        if (out_data !== 8'hB5 || out_ovf !== 2'b00) begin
            bad++;
            $display("FAIL basic_result: got data=%h ovf=%b want B5/00", out_data, out_ovf);
        end
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_out_state: got in_ready=%b busy=%b want 0/1", in_ready, busy);
        end
        handshake();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_release: got valid=%b in_ready=%b busy=%b want 0/1/0",
                     out_valid, in_ready, busy);
        end
    endtask

    task automatic test_same_cycle_write();
        int nacc;
        bit vlast, early;
        // First beat and an overwrite of its own weight in the same IDLE cycle.
        in_valid = 1'b1;
        in_data  = D_ONE;
        wgt_we   = 1'b1;
        wgt_addr = ADW'(widx(0, 0, 0));
        wgt_data = W_M1;
        tick();
        wgt_we   = 1'b0;
        run_vec(D_ONE, 4, D_ZERO, 1'b0, VL - 1, nacc, vlast, early);
        total++;
        if (vlast !== 1'b1 || out_data !== 8'hB5 || out_ovf !== 2'b00) begin
            bad++;
            $display("FAIL same_cycle_old_weight: got valid=%b data=%h ovf=%b want 1/B5/00",
                     vlast, out_data, out_ovf);
        end
        handshake();
        run_vec(D_ONE, 5, D_ZERO, 1'b0, VL, nacc, vlast, early);
        total++;
        if (out_data !== 8'hB3 || out_ovf !== 2'b00) begin
            bad++;
            $display("FAIL same_cycle_committed: got data=%h ovf=%b want B3/00", out_data, out_ovf);
        end
        handshake();
        poke_weight(widx(0, 0, 0), W_P1);
    endtask

    task automatic test_saturation();
        int nacc;
        bit vlast, early;
        load_neuron(1, W_M2);
        run_vec(D_ALL3, VL, D_ALL3, 1'b0, VL, nacc, vlast, early);
        total++;
        if (vlast !== 1'b1 || out_data !== 8'h87 || out_ovf !== 2'b11) begin
            bad++;
            $display("FAIL saturation: got valid=%b data=%h ovf=%b want 1/87/11",
                     vlast, out_data, out_ovf);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        int nacc;
        int errs;
        bit vlast, early;
        run_vec(D_ALL3, VL, D_ALL3, 1'b0, VL, nacc, vlast, early);
        errs = 0;
        // Hold the result; offer beats and a weight write that must be ignored.
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = D_ALL3;
            wgt_we   = 1'b1;
            wgt_addr = ADW'(widx(0, 0, 0));
            wgt_data = W_M1;
            tick();
            if (out_valid !== 1'b1 || out_data !== 8'h87 || in_ready !== 1'b0) errs++;
        end
        in_valid = 1'b0;
        wgt_we   = 1'b0;
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL backpressure_hold: %0d unstable cycles, want 0", errs);
        end
        handshake();
        run_vec(D_ONE, 5, D_ZERO, 1'b0, VL, nacc, vlast, early);
        total++;
        if (nacc !== VL || vlast !== 1'b1 || out_data !== 8'h85 || out_ovf !== 2'b10) begin
            bad++;
            $display("FAIL backpressure_next: accepted=%0d valid=%b data=%h ovf=%b want %0d/1/85/10",
                     nacc, vlast, out_data, out_ovf, VL);
        end
        handshake();
    endtask

    task automatic test_bubbles();
        int nacc;
        bit vlast, early;
        load_neuron(1, W_M1);
        run_vec(D_ONE, 5, D_ZERO, 1'b1, VL, nacc, vlast, early);
        total++;
        if (nacc !== VL || vlast !== 1'b1 || early !== 1'b0) begin
            bad++;
            $display("FAIL bubbles_count: accepted=%0d valid_after_last=%b early=%b, want %0d/1/0",
                     nacc, vlast, early, VL);
        end
        total++;
        if (out_data !== 8'hB5 || out_ovf !== 2'b00) begin
            bad++;
            $display("FAIL bubbles_result: got data=%h ovf=%b want B5/00", out_data, out_ovf);
        end
        handshake();
    endtask

    task automatic test_mid_events();
        int nacc;
        bit vlast, early;
        run_vec(D_ONE, 5, D_ZERO, 1'b0, 10, nacc, vlast, early);
        // Write attempt while accumulating must not land.
        poke_weight(widx(1, 0, 0), W_P1);
        run_vec(D_ZERO, 0, D_ZERO, 1'b0, 10, nacc, vlast, early);
        total++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_busy: got busy=%b valid=%b want 1/0", busy, out_valid);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ovf !== 2'b00 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got valid=%b data=%h ovf=%b busy=%b want 0/00/00/0",
                     out_valid, out_data, out_ovf, busy);
        end
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_in_ready: got %b want 1", in_ready);
        end
        run_vec(D_ONE, 5, D_ZERO, 1'b0, VL, nacc, vlast, early);
        total++;
        if (nacc !== VL || vlast !== 1'b1 || out_data !== 8'hB5 || out_ovf !== 2'b00) begin
            bad++;
            $display("FAIL mid_rerun: accepted=%0d valid=%b data=%h ovf=%b want %0d/1/B5/00",
                     nacc, vlast, out_data, out_ovf, VL);
        end
        handshake();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_same_cycle_write();
        test_saturation();
        test_backpressure();
        test_bubbles();
        test_mid_events();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bnn_fc_mac_array.md
Name: bnn_fc_mac_array

Overview:
Parametrised fully-connected MAC engine for the BNN-VAD classifier head. It streams IN_LANES quantised activations per beat over VEC_LEN beats and accumulates N_OUT neuron dot products in parallel against a runtime-loadable signed weight memory. It emits saturated per-neuron scores with overflow flags.
Sits between the feature/conv stage (upstream, valid/ready) and the decision logic (downstream, valid/ready).

Parameters:
IN_LANES, 3, activations per input beat
VEC_LEN, 36, beats per input vector (vector length = IN_LANES*VEC_LEN)
N_OUT, 2, output neurons computed in parallel
ACT_W, 2, activation width, unsigned
WGT_W, 2, weight width, signed two's complement
ACC_W, 12, accumulator width, signed; must hold IN_LANES*VEC_LEN*max|act*wgt|
OUT_W, 4, output score width, signed, saturated
ADDR_W, $clog2(N_OUT*VEC_LEN*IN_LANES), weight address width (8 at defaults)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
wgt_we  in  1  weight write strobe
wgt_addr  in  ADDR_W  weight index = (n*VEC_LEN + beat)*IN_LANES + lane
wgt_data  in  WGT_W  signed weight
in_valid  in  1  activation beat valid
in_ready  out  1  engine accepts beat
in_data  in  IN_LANES*ACT_W  lane 0 in LSBs
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  N_OUT*OUT_W  neuron 0 in LSBs, saturated signed
out_ovf  out  N_OUT  per-neuron saturation flag
busy  out  1  high in ACC or OUT

Behaviour:
- Reset (async assert, sync release): state=IDLE, beat counter=0, accumulators=0, out_valid=0, out_data=0, out_ovf=0, busy=0. in_ready=1 from the first cycle after release. Weight memory is NOT reset; contents persist across rst_n.
- States: IDLE, ACC, OUT.
  - IDLE: in_ready=1. Accepted beat (in_valid&in_ready) -> accumulators load beat-0 partial sums (not add to stale values), cnt=1, go ACC. If VEC_LEN==1 go straight to OUT.
  - ACC: in_ready=1. Each accepted beat adds lane products for weights at beat cnt; cnt++. Accepted beat with cnt==VEC_LEN-1 -> OUT, cnt=0. in_valid low -> hold, no accumulation.
  - OUT: in_ready=0, out_valid=1. out_data/out_ovf are registered and stable until handshake. out_valid&out_ready -> IDLE next cycle. in_valid during OUT is ignored.
- Latency: out_valid rises the cycle after the last beat is accepted. Throughput: VEC_LEN+1 cycles per vector with out_ready tied high.
- Arithmetic:
  - product = $signed({1'b0,act}) * wgt, width ACT_W+WGT_W+1.
  - Per-neuron beat sum is sign-extended to ACC_W and added to the accumulator; the accumulator wraps only if ACC_W is misconfigured (assert in sim).
- Saturation on entry to OUT: acc > 2^(OUT_W-1)-1 -> max, ovf=1; acc < -2^(OUT_W-1) -> min, ovf=1; otherwise truncate exactly, ovf=0.
- Weight writes: accepted only in IDLE. wgt_we in ACC/OUT is ignored, with no side effect. Same-cycle write and first beat accepted in IDLE: write commits, but beat 0 uses the old value. wgt_addr >= N_OUT*VEC_LEN*IN_LANES is ignored.
- Reset mid-vector: partial sums are discarded and the next vector starts clean; weights are retained.

Decomposition:
- Package bnn_fc_pkg holds:
  - state enum (IDLE/ACC/OUT)
  - default parameter constants
  - function sat_to_out(acc) returning {ovf, value}
  - function widx(n, beat, lane)
- One sub-module bnn_fc_lane_dot: combinational IN_LANES-wide act*wgt product and adder tree for a single neuron, instantiated N_OUT times. The top holds the FSM, counter, memory, accumulators and output registers.

Test Plan:
- Reset: rst_n low mid-run -> out_valid=0, out_data=0, out_ovf=0, busy=0. in_ready=1 the cycle after release.
- Basic: load n0 all +1, n1 all -1. Feed 36 beats, first 5 with in_data lanes={0,0,1}, rest 0 -> out_data n0=5, n1=-5, out_ovf=00. out_valid rises exactly 1 cycle after beat 36.
- Saturation: all activations 3, n0 weights +1, n1 weights -2 -> raw 324 / -648 -> n0=7, n1=-8, out_ovf=11.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 -> out_data stable, in_ready=0, no beats consumed. After the handshake, the next vector gives the correct result.
- Bubbles: same vector as Basic with in_valid toggling randomly -> identical result (5/-5), 36 accepted beats counted.
- Mid-op events: wgt_we during ACC (write +1 over a -1) and rst_n pulse at beat 20. The rerun vector uses the unchanged old weights and produces the Basic result.
